// File: rtl/qsys_nios2_gen2_cpu_debug_host_pkg.sv
// Shared definitions for the Nios II debug-host JTAG initiator.
// Holds the TAP sequencer state encoding, the fixed tms patterns of the
// header/tail segments (applied LSB first) and a helper that returns the
// tms value of a fixed segment bit.
package qsys_nios2_gen2_cpu_debug_host_pkg;

    typedef enum logic [3:0] {
        TLR_SEQ,
        IDLE,
        IR_HDR,
        IR_SHIFT,
        IR_TAIL,
        DR_HDR,
        DR_SHIFT,
        DR_TAIL,
        RESP
    } tap_seq_t;

    // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] IR_HDR_TMS = 4'b0011;
    // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [2:0] DR_HDR_TMS = 3'b001;
    // Exit1 -> Update -> Run-Test/Idle
    localparam logic [1:0] TAIL_TMS   = 2'b01;

    localparam int TLR_LEN    = 6;
    localparam int IR_HDR_LEN = 4;
    localparam int DR_HDR_LEN = 3;
    localparam int TAIL_LEN   = 2;

    // tms for bit idx of a fixed-pattern segment (not valid for shift states)
    function automatic logic fixed_tms(input tap_seq_t st, input logic [2:0] idx);
        logic [3:0] dr_pat;
        dr_pat = {1'b0, DR_HDR_TMS};
        case (st)
            TLR_SEQ: return (idx < 3'(TLR_LEN - 1));
            IR_HDR:  return IR_HDR_TMS[idx[1:0]];
            DR_HDR:  return dr_pat[idx[1:0]];
            IR_TAIL,
            DR_TAIL: return TAIL_TMS[idx[0]];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/qsys_nios2_gen2_cpu_debug_host_tck_gen.sv
// tck divider for the debug-host JTAG initiator.
// One JTAG bit = CLK_DIV clk cycles with tck low, then CLK_DIV with tck high.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   enable          run the divider; when low tck is held 0 and the phase restarts
//   tck             JTAG clock (registered)
//   rise_tick       high in the cycle whose closing clk edge drives tck 0->1
//   fall_tick       high in the cycle whose closing clk edge drives tck 1->0
//                   (that edge also begins the next bit)
module qsys_nios2_gen2_cpu_debug_host_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] FALL_AT = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          tck_reg;

    assign rise_tick = enable && (cnt_reg == RISE_AT);
    assign fall_tick = enable && (cnt_reg == FALL_AT);
    assign tck       = tck_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else if (!enable || fall_tick) begin
            cnt_reg <= '0;
            tck_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (rise_tick) begin
                tck_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/qsys_nios2_gen2_cpu_debug_host_jtag.sv
// JTAG-side initiator for the Nios II debug slave's virtual-JTAG link.
// After reset it walks the TAP to Run-Test/Idle, then accepts one command at
// a time: an optional IR scan followed by one DR scan, both LSB first, and
// returns the tdo bits captured during the shifts.
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_skip_ir, cmd_ir, cmd_dr command fields, captured on handshake
//   rsp_valid/rsp_ready        response handshake
//   rsp_ir, rsp_dr             captured tdo bits (rsp_ir = 0 when IR skipped)
//   tck, tms, tdi, tdo         JTAG pins
module qsys_nios2_gen2_cpu_debug_host_jtag
    import qsys_nios2_gen2_cpu_debug_host_pkg::*;
#(
    parameter int IR_W    = 2,
    parameter int DR_W    = 38,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_skip_ir,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_dr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IR_W-1:0] rsp_ir,
    output logic [DR_W-1:0] rsp_dr,
    output logic            tck,
    output logic            tms,
    output logic            tdi,
    input  logic            tdo
);

    localparam int MAX_W = (IR_W > DR_W) ? IR_W : DR_W;
    // The same counter also indexes the fixed segments, so never narrower
    // than the reset walk needs.
    localparam int CNT_W = $clog2(((MAX_W > TLR_LEN) ? MAX_W : TLR_LEN) + 1);

    tap_seq_t        state_reg, state_next;
    logic [CNT_W-1:0] bit_reg, bit_next;
    logic            tms_reg, tms_next;
    logic            tdi_reg, tdi_next;
    logic [IR_W-1:0] ir_tx_reg, ir_tx_next;
    logic [DR_W-1:0] dr_tx_reg, dr_tx_next;
    logic [IR_W-1:0] rsp_ir_reg;
    logic [DR_W-1:0] rsp_dr_reg;
    logic            rsp_valid_reg;

    logic tck_en;
    logic rise_tick;
    logic fall_tick;
    logic accept;
    logic issue;

    function automatic logic [CNT_W-1:0] seg_len(input tap_seq_t st);
        case (st)
            TLR_SEQ:  return CNT_W'(TLR_LEN);
            IR_HDR:   return CNT_W'(IR_HDR_LEN);
            IR_SHIFT: return CNT_W'(IR_W);
            DR_HDR:   return CNT_W'(DR_HDR_LEN);
            DR_SHIFT: return CNT_W'(DR_W);
            IR_TAIL,
            DR_TAIL:  return CNT_W'(TAIL_LEN);
            default:  return CNT_W'(1);
        endcase
    endfunction

    function automatic tap_seq_t seg_succ(input tap_seq_t st);
        case (st)
            TLR_SEQ:  return IDLE;
            IR_HDR:   return IR_SHIFT;
            IR_SHIFT: return IR_TAIL;
            IR_TAIL:  return DR_HDR;
            DR_HDR:   return DR_SHIFT;
            DR_SHIFT: return DR_TAIL;
            DR_TAIL:  return RESP;
            default:  return st;
        endcase
    endfunction

    assign tck_en    = (state_reg != IDLE) && (state_reg != RESP);
    assign cmd_ready = (state_reg == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    qsys_nios2_gen2_cpu_debug_host_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk       (clk),
        .reset     (reset),
        .enable    (tck_en),
        .tck       (tck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Next state plus the tms/tdi of the bit that starts at the next edge.
    // A bit's pins are set on the edge that begins it: the handshake edge
    // for the first header bit, otherwise the tck falling edge.
    always_comb begin
        state_next = state_reg;
        bit_next   = bit_reg;
        tms_next   = tms_reg;
        tdi_next   = tdi_reg;
        ir_tx_next = ir_tx_reg;
        dr_tx_next = dr_tx_reg;
        issue      = 1'b0;

        case (state_reg)
            IDLE: begin
                tms_next = 1'b0;
                tdi_next = 1'b0;
                if (accept) begin
                    state_next = cmd_skip_ir ? DR_HDR : IR_HDR;
                    bit_next   = '0;
                    tms_next   = 1'b1;
                    ir_tx_next = cmd_ir;
                    dr_tx_next = cmd_dr;
                end
            end
            RESP: begin
                tms_next = 1'b0;
                tdi_next = 1'b0;
                if (rsp_valid_reg && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (fall_tick) begin
                    issue = 1'b1;
                    if (bit_reg == seg_len(state_reg) - 1'b1) begin
                        state_next = seg_succ(state_reg);
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
        endcase

        if (issue) begin
            case (state_next)
                IR_SHIFT: begin
                    tms_next   = (bit_next == CNT_W'(IR_W - 1));
                    tdi_next   = ir_tx_reg[0];
                    ir_tx_next = ir_tx_reg >> 1;
                end
                DR_SHIFT: begin
                    tms_next   = (bit_next == CNT_W'(DR_W - 1));
                    tdi_next   = dr_tx_reg[0];
                    dr_tx_next = dr_tx_reg >> 1;
                end
                IDLE,
                RESP: begin
                    tms_next = 1'b0;
                    tdi_next = 1'b0;
                end
                default: begin
                    tms_next = fixed_tms(state_next, bit_next[2:0]);
                    tdi_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= TLR_SEQ;
            bit_reg       <= '0;
            tms_reg       <= 1'b1;
            tdi_reg       <= 1'b0;
            ir_tx_reg     <= '0;
            dr_tx_reg     <= '0;
            rsp_ir_reg    <= '0;
            rsp_dr_reg    <= '0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            bit_reg   <= bit_next;
            tms_reg   <= tms_next;
            tdi_reg   <= tdi_next;
            ir_tx_reg <= ir_tx_next;
            dr_tx_reg <= dr_tx_next;

            // Captured bits enter at the top and walk down, so the first
            // tdo bit ends up in bit 0.
            if (accept) begin
                rsp_ir_reg <= '0;
                rsp_dr_reg <= '0;
            end else if (rise_tick && state_reg == IR_SHIFT) begin
                rsp_ir_reg <= {tdo, rsp_ir_reg[IR_W-1:1]};
            end else if (rise_tick && state_reg == DR_SHIFT) begin
                rsp_dr_reg <= {tdo, rsp_dr_reg[DR_W-1:1]};
            end

            // Rises one clk after the last tck falling edge; drops on consume.
            if (state_reg == RESP) begin
                rsp_valid_reg <= !(rsp_valid_reg && rsp_ready);
            end else begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign tms       = tms_reg;
    assign tdi       = tdi_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_ir    = rsp_ir_reg;
    assign rsp_dr    = rsp_dr_reg;

endmodule
